// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the packet-aware round-robin egress arbiter.
// Index helpers assume at most 32 requesters.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int onehot2bin(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the lowest request above ptr wins,
// otherwise the lowest request overall.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N     = 7,
    parameter int SRC_W = safe_clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SRC_W-1:0] idx
);

    logic [N-1:0] masked;
    logic [N-1:0] masked_gnt;
    logic [N-1:0] plain_gnt;

    always_comb begin
        masked     = '0;
        masked_gnt = '0;
        plain_gnt  = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (i > int'(ptr));
        end
        // Scanning downward leaves the lowest set bit as the survivor.
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                masked_gnt    = '0;
                masked_gnt[i] = 1'b1;
            end
            if (req[i]) begin
                plain_gnt    = '0;
                plain_gnt[i] = 1'b1;
            end
        end
        grant = (|masked) ? masked_gnt : plain_gnt;
        idx   = SRC_W'(onehot2bin(32'(grant)));
    end

endmodule

// File: rtl/rr_arb_pkt_egress.sv
// Packet-aware round-robin egress: holds the grant for a whole packet and
// drives a registered valid/ready output slice tagged with the source index.
module rr_arb_pkt_egress
    import rr_arb_pkg::*;
#(
    parameter  int REQ_NUM = 7,
    parameter  int DW      = 32,
    localparam int SRC_W   = safe_clog2(REQ_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REQ_NUM-1:0]    in_valid,
    input  logic [REQ_NUM*DW-1:0] in_data,
    input  logic [REQ_NUM-1:0]    in_last,
    output logic [REQ_NUM-1:0]    in_ready,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic                  out_last,
    output logic [SRC_W-1:0]      out_src,
    input  logic                  out_ready
);

    state_t             state;
    state_t             state_nxt;
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   lock_id;
    logic [REQ_NUM-1:0] pick_grant;
    logic [SRC_W-1:0]   pick_idx;
    logic [SRC_W-1:0]   cur_idx;
    logic               load_en;
    logic               xfer;
    logic               cur_last;
    logic [DW-1:0]      cur_data;

    rr_pick #(
        .N     (REQ_NUM),
        .SRC_W (SRC_W)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign load_en = !out_valid || out_ready;

    // in_ready depends only on state, pointer, valids and the output slot.
    always_comb begin
        in_ready = '0;
        cur_idx  = pick_idx;
        if (state == LOCK) begin
            cur_idx           = lock_id;
            in_ready[lock_id] = load_en;
        end else if (load_en) begin
            in_ready = pick_grant;
        end
        if (REQ_NUM == 1) begin
            in_ready = {REQ_NUM{load_en}};
            cur_idx  = '0;
        end
        xfer     = |(in_valid & in_ready);
        cur_last = in_last[cur_idx];
        cur_data = in_data[int'(cur_idx) * DW +: DW];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (xfer && !cur_last) state_nxt = LOCK;
            LOCK: if (xfer && cur_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= SRC_W'(REQ_NUM - 1);
            lock_id   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && xfer) begin
                ptr     <= cur_idx;
                lock_id <= cur_idx;
            end
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= cur_data;
                    out_last <= cur_last;
                    out_src  <= cur_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_pkt_egress.sv
// Self-checking bench for rr_arb_pkt_egress: directed scenarios plus
// randomized traffic compared against a packet-level reference model.
module tb_rr_arb_pkt_egress;

    localparam int N  = 7;
    localparam int DW = 32;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [SW-1:0]   out_src;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: output slot contents, rotation pointer, packet owner (-1 = none).
    bit            m_valid = 0;
    bit            m_last  = 0;
    logic [DW-1:0] m_data  = '0;
    int            m_src   = 0;
    int            m_ptr   = N - 1;
    int            m_owner = -1;

    always #5 clk = ~clk;

    rr_arb_pkt_egress #(
        .REQ_NUM (N),
        .DW      (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int           w;
        bit           le;
        r  = '0;
        w  = -1;
        le = !m_valid || out_ready;
        if (m_owner >= 0) begin
            w = m_owner;
        end else begin
            for (int i = N - 1; i > m_ptr; i--) if (in_valid[i]) w = i;
            if (w < 0) for (int i = N - 1; i >= 0; i--) if (in_valid[i]) w = i;
        end
        if (w >= 0) r[w] = le;
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rand_data();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    // Advance one clock and move the model along with it.
    task automatic tick();
        logic [N-1:0] rdy;
        bit           le;
        int           w;
        rdy = model_ready();
        le  = !m_valid || out_ready;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = '0; m_last = 0; m_src = 0;
            m_ptr = N - 1; m_owner = -1;
        end else begin
            w = -1;
            for (int i = 0; i < N; i++) if (rdy[i] && in_valid[i]) w = i;
            if (le) begin
                m_valid = (w >= 0);
                if (w >= 0) begin
                    m_data = in_data[w*DW +: DW];
                    m_last = in_last[w];
                    m_src  = w;
                    if (m_owner < 0) begin
                        m_ptr = w;
                        if (!in_last[w]) m_owner = w;
                    end else if (in_last[w]) begin
                        m_owner = -1;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = '0; in_last = '0; in_data = rand_data(); out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last got %0b want 0", out_last); end
        checks++; if (out_src !== '0) begin errors++; $display("[TB] FAIL reset_out_src got %0d want 0", out_src); end
        checks++; if (in_ready !== '0) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    endtask

    task automatic test_alternate();
        int            exp_src[4] = '{0, 2, 0, 2};
        logic [DW-1:0] sent;
        in_valid = 7'b0000101; in_last = '1; out_ready = 1'b1; in_data = rand_data();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL alt_pre_valid got %0b want 0", out_valid); end
        for (int k = 0; k < 4; k++) begin
            in_data = rand_data();
            sent    = in_data[exp_src[k]*DW +: DW];
            tick();
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL alt_valid[%0d] got %0b want 1", k, out_valid); end
            checks++; if (out_src !== SW'(exp_src[k])) begin errors++; $display("[TB] FAIL alt_src[%0d] got %0d want %0d", k, out_src, exp_src[k]); end
            checks++; if (out_data !== sent) begin errors++; $display("[TB] FAIL alt_data[%0d] got %h want %h", k, out_data, sent); end
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_lock();
        logic [DW-1:0] sent;
        in_valid = 7'b0101010; in_last = 7'b0100010; out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            in_last[3] = (b == 3);
            in_data    = rand_data();
            sent       = in_data[3*DW +: DW];
            #1;
            checks++; if (in_ready !== 7'b0001000) begin errors++; $display("[TB] FAIL lock_ready[%0d] got %b want 0001000", b, in_ready); end
            tick();
            #1;
            checks++; if (out_src !== 3'd3 || out_data !== sent) begin errors++; $display("[TB] FAIL lock_beat[%0d] got src %0d data %h want src 3 data %h", b, out_src, out_data, sent); end
        end
        #1;
        checks++; if (in_ready !== 7'b0100000) begin errors++; $display("[TB] FAIL lock_next5 got %b want 0100000", in_ready); end
        tick();
        #1;
        checks++; if (out_src !== 3'd5) begin errors++; $display("[TB] FAIL lock_src5 got %0d want 5", out_src); end
        tick();
        #1;
        checks++; if (out_src !== 3'd1) begin errors++; $display("[TB] FAIL lock_src1 got %0d want 1", out_src); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] sent;
        logic [DW-1:0] sent2;
        in_valid = 7'b0000001; in_last = '1; out_ready = 1'b1; in_data = rand_data();
        sent = in_data[DW-1:0];
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_data = rand_data();
            #1;
            checks++; if (in_ready !== '0) begin errors++; $display("[TB] FAIL bp_ready[%0d] got %b want 0", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== sent || out_src !== '0 || out_last !== 1'b1) begin
                errors++; $display("[TB] FAIL bp_hold[%0d] got v%0b d%h s%0d l%0b want v1 d%h s0 l1", c, out_valid, out_data, out_src, out_last, sent);
            end
            tick();
        end
        out_ready = 1'b1;
        in_data   = rand_data();
        sent2     = in_data[DW-1:0];
        #1;
        checks++; if (in_ready !== 7'b0000001) begin errors++; $display("[TB] FAIL bp_release_ready got %b want 0000001", in_ready); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== sent2) begin errors++; $display("[TB] FAIL bp_release_data got v%0b d%h want v1 d%h", out_valid, out_data, sent2); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_wrap();
        in_valid = 7'b1000000; in_last = '1; out_ready = 1'b1; in_data = rand_data();
        #1;
        checks++; if (in_ready !== 7'b1000000) begin errors++; $display("[TB] FAIL wrap_setup got %b want 1000000", in_ready); end
        tick();
        in_valid = 7'b1000001;
        #1;
        checks++; if (in_ready !== 7'b0000001) begin errors++; $display("[TB] FAIL wrap_grant0 got %b want 0000001", in_ready); end
        tick();
        #1;
        checks++; if (out_src !== 3'd0) begin errors++; $display("[TB] FAIL wrap_src0 got %0d want 0", out_src); end
        checks++; if (in_ready !== 7'b1000000) begin errors++; $display("[TB] FAIL wrap_grant6 got %b want 1000000", in_ready); end
        tick();
        #1;
        checks++; if (out_src !== 3'd6) begin errors++; $display("[TB] FAIL wrap_src6 got %0d want 6", out_src); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_gap();
        in_valid = 7'b0010100; in_last = 7'b0010000; out_ready = 1'b1; in_data = rand_data();
        #1;
        checks++; if (in_ready !== 7'b0000100) begin errors++; $display("[TB] FAIL gap_first got %b want 0000100", in_ready); end
        tick();
        in_valid = 7'b0010000;
        for (int g = 0; g < 2; g++) begin
            #1;
            checks++; if (in_ready !== 7'b0000100) begin errors++; $display("[TB] FAIL gap_ready[%0d] got %b want 0000100", g, in_ready); end
            tick();
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL gap_bubble[%0d] got %0b want 0", g, out_valid); end
        end
        in_valid = 7'b0010100; in_last = 7'b0010100;
        tick();
        #1;
        checks++; if (out_src !== 3'd2 || out_last !== 1'b1) begin errors++; $display("[TB] FAIL gap_last got src %0d last %0b want src 2 last 1", out_src, out_last); end
        tick();
        #1;
        checks++; if (out_src !== 3'd4) begin errors++; $display("[TB] FAIL gap_src4 got %0d want 4", out_src); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        in_valid = 7'b0000010; in_last = '0; out_ready = 1'b1; in_data = rand_data();
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %0b want 0", out_valid); end
        in_valid = 7'b0000011; in_last = '1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 7'b0000001) begin errors++; $display("[TB] FAIL rstmid_grant got %b want 0000001", in_ready); end
        tick();
        #1;
        checks++; if (out_src !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_src got %0d want 0", out_src); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_rdy;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = N'($urandom);
            in_last   = N'($urandom & $urandom);
            in_data   = rand_data();
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = model_ready();
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("[TB] FAIL rand_ready[%0d] got %b want %b", c, in_ready, exp_rdy); end
            checks++; if (out_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid[%0d] got %0b want %0b", c, out_valid, m_valid); end
            if (m_valid) begin
                checks++;
                if (out_data !== m_data || out_last !== m_last || out_src !== SW'(m_src)) begin
                    errors++; $display("[TB] FAIL rand_beat[%0d] got d%h l%0b s%0d want d%h l%0b s%0d", c, out_data, out_last, out_src, m_data, m_last, m_src);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_alternate();
        test_lock();
        test_backpressure();
        test_wrap();
        test_gap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
